// File: rtl/fpga_spi_master_if.sv
// Host/peripheral-facing signal bundle for fpga_spi_master.
// The master modport is the SPI engine's view; slave is the host/board side.
interface fpga_spi_master_if #(
    parameter int DATA_W = 8,
    parameter int CS_N   = 3
);
    logic [1:0]        Mode;
    logic [DATA_W-1:0] data_to_send;
    logic              write_ready;
    logic              read_ready;
    logic [1:0]        secondary_num_i;
    logic              flag_inv_i;
    logic              MISO;
    logic              MOSI;
    logic [CS_N-1:0]   CS;
    logic              SCLK;
    logic              ready_send;
    logic              ready_read;
    logic [DATA_W-1:0] recieved_data;

    modport master (
        input  Mode, data_to_send, write_ready, read_ready,
        input  secondary_num_i, flag_inv_i, MISO,
        output MOSI, CS, SCLK, ready_send, ready_read, recieved_data
    );

    modport slave (
        output Mode, data_to_send, write_ready, read_ready,
        output secondary_num_i, flag_inv_i, MISO,
        input  MOSI, CS, SCLK, ready_send, ready_read, recieved_data
    );
endinterface

// File: rtl/fpga_spi_master.sv
// Single-channel SPI master, CS_N chip selects, all four CPOL/CPHA modes.
// One 8-bit write or one 8-bit read per request, level-ready handshake.
// SCLK runs at CLK/2; request to ready rising is 2*DATA_W+2 cycles.
// Optional macro FPGA_SPI_LSB_FIRST_EN: shift LSB first instead of MSB first.
module fpga_spi_master #(
    parameter int DATA_W = 8,
    parameter int CS_N   = 3
) (
    input logic               CLK,
    input logic               Reset,
    fpga_spi_master_if.master bus
);
    localparam int               CNT_W    = $clog2(2 * DATA_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(2 * DATA_W - 1);

`ifdef FPGA_SPI_LSB_FIRST_EN
    localparam int FIRST_BIT = 0;

    function automatic logic [DATA_W-1:0] shift_tx(input logic [DATA_W-1:0] w);
        return w >> 1;
    endfunction

    function automatic logic [DATA_W-1:0] shift_rx(input logic [DATA_W-1:0] w, input logic b);
        return {b, w[DATA_W-1:1]};
    endfunction
`else
    localparam int FIRST_BIT = DATA_W - 1;

    function automatic logic [DATA_W-1:0] shift_tx(input logic [DATA_W-1:0] w);
        return w << 1;
    endfunction

    function automatic logic [DATA_W-1:0] shift_rx(input logic [DATA_W-1:0] w, input logic b);
        return {w[DATA_W-2:0], b};
    endfunction
`endif

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, DONE} state_t;

    state_t            state, state_next;
    logic [1:0]        mode_q;
    logic              inv_q;
    logic [1:0]        sel_q;
    logic              is_write_q;
    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] rx_sr;
    logic [DATA_W-1:0] rx_data;
    logic [CNT_W-1:0]  cnt;
    logic              sclk_q;
    logic              mosi_q;
    logic              sel_ok;
    logic              accept;
    logic              upd_edge;
    logic [CS_N-1:0]   cs_sel;
    logic [CS_N-1:0]   cs_out;
    logic              ready_send_c;
    logic              ready_read_c;

    // Out-of-range slave index drops the request entirely
    assign sel_ok   = 32'(bus.secondary_num_i) < CS_N;
    assign accept   = (bus.write_ready | bus.read_ready) & sel_ok;
    // Even cnt = leading SCLK edge; CPHA=0 updates MOSI on trailing, CPHA=1 on leading
    assign upd_edge = cnt[0] ^ mode_q[0];

    // State register
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus chip-select and ready flags
    always_comb begin
        state_next   = state;
        cs_sel       = CS_N'(1) << sel_q;
        cs_out       = {CS_N{~inv_q}};
        ready_send_c = 1'b1;
        ready_read_c = 1'b1;

        case (state)
            IDLE:    if (accept) state_next = SETUP;
            SETUP:   state_next = SHIFT;
            SHIFT:   if (cnt == LAST_CNT) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        if (state == SETUP || state == SHIFT) begin
            cs_out = inv_q ? cs_sel : ~cs_sel;
        end

        if (state != IDLE) begin
            if (is_write_q) ready_send_c = 1'b0;
            else            ready_read_c = 1'b0;
        end
    end

    // Request latching, SCLK generation and the shift datapath
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            mode_q     <= '0;
            inv_q      <= 1'b0;
            sel_q      <= '0;
            is_write_q <= 1'b0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            rx_data    <= '0;
            cnt        <= '0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    sclk_q <= mode_q[1];
                    mosi_q <= 1'b0;
                    cnt    <= '0;
                    if (accept) begin
                        mode_q     <= bus.Mode;
                        inv_q      <= bus.flag_inv_i;
                        sel_q      <= bus.secondary_num_i;
                        is_write_q <= bus.write_ready;
                        sclk_q     <= bus.Mode[1];
                        if (!bus.write_ready) begin
                            tx_sr <= '0;
                        end else if (bus.Mode[0]) begin
                            tx_sr <= bus.data_to_send;
                        end else begin
                            // CPHA=0 presents the first bit before any SCLK edge
                            mosi_q <= bus.data_to_send[FIRST_BIT];
                            tx_sr  <= shift_tx(bus.data_to_send);
                        end
                    end
                end
                SETUP: begin
                end
                SHIFT: begin
                    sclk_q <= ~sclk_q;
                    cnt    <= cnt + 1'b1;
                    if (upd_edge) begin
                        mosi_q <= tx_sr[FIRST_BIT];
                        tx_sr  <= shift_tx(tx_sr);
                    end else if (!is_write_q) begin
                        rx_sr <= shift_rx(rx_sr, bus.MISO);
                    end
                end
                DONE: begin
                    sclk_q <= mode_q[1];
                    mosi_q <= 1'b0;
                    if (!is_write_q) rx_data <= rx_sr;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.SCLK          = sclk_q;
    assign bus.MOSI          = mosi_q;
    assign bus.CS            = cs_out;
    assign bus.ready_send    = ready_send_c;
    assign bus.ready_read    = ready_read_c;
    assign bus.recieved_data = rx_data;
endmodule

// File: tb/tb_fpga_spi_master.sv
// Scoreboard bench for fpga_spi_master: a slave model drives MISO and
// captures MOSI on its sampling edges; expected words are queued at request
// time and compared when the matching ready flag rises.
module tb_fpga_spi_master;
    localparam int DATA_W = 8;
    localparam int CS_N   = 3;

    logic CLK = 1'b0;
    logic Reset;

    fpga_spi_master_if #(.DATA_W(DATA_W), .CS_N(CS_N)) bus ();

    fpga_spi_master #(.DATA_W(DATA_W), .CS_N(CS_N)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit         is_write;
        logic [7:0] value;
    } sb_item_t;

    sb_item_t   sb_q[$];
    int         errors = 0;
    int         checks = 0;
    logic [1:0] cur_mode = 2'b00;
    logic [7:0] slave_word = 8'h00;
    bit         active = 1'b0;
    int         xfer_id = 0;
    int         seen_id = 0;
    int         leads = 0;
    int         trails = 0;
    logic [7:0] cap = 8'h00;
    logic [7:0] last_read = 8'h00;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic miso_bit(input logic [7:0] w, input logic cpha, input int l, input int t);
        int idx;
        idx = cpha ? ((l > 0) ? l - 1 : 0) : t;
        if (idx > 7) return 1'b0;
`ifdef FPGA_SPI_LSB_FIRST_EN
        return w[idx];
`else
        return w[7 - idx];
`endif
    endfunction

    function automatic logic [7:0] cap_shift(input logic [7:0] w, input logic b);
`ifdef FPGA_SPI_LSB_FIRST_EN
        return {b, w[7:1]};
`else
        return {w[6:0], b};
`endif
    endfunction

    assign bus.MISO = miso_bit(slave_word, cur_mode[0], leads, trails);

    // Slave model: count SCLK edges, capture MOSI on the slave sampling edge
    always @(bus.SCLK or xfer_id) begin
        if (seen_id != xfer_id) begin
            seen_id = xfer_id;
            leads   = 0;
            trails  = 0;
            cap     = 8'h00;
        end else if (active) begin
            if (bus.SCLK !== cur_mode[1]) begin
                leads++;
                if (!cur_mode[0]) cap = cap_shift(cap, bus.MOSI);
            end else if (leads > trails) begin
                trails++;
                if (cur_mode[0]) cap = cap_shift(cap, bus.MOSI);
            end
        end
    end

    task automatic transfer(input string name, input bit wr, input bit rd_too,
                            input logic [1:0] mode, input logic [1:0] slv, input bit inv,
                            input logic [7:0] data, input int hold);
        logic [2:0] exp_cs;
        logic [7:0] act;
        sb_item_t   item;
        int         low;
        bit         done, cs_ok, mosi_zero, other_ok;
        logic       rdy;

        exp_cs = 3'(3'b001 << slv);
        if (!inv) exp_cs = ~exp_cs;

        @(negedge CLK);
        bus.Mode            = mode;
        bus.secondary_num_i = slv;
        bus.flag_inv_i      = inv;
        bus.data_to_send    = wr ? data : 8'h00;
        cur_mode            = mode;
        slave_word          = wr ? 8'hFF : data;
        active              = 1'b1;
        xfer_id++;
        bus.write_ready     = wr;
        bus.read_ready      = !wr || rd_too;
        sb_q.push_back('{wr, data});

        low = 0; done = 0; cs_ok = 1; mosi_zero = 1; other_ok = 1;
        for (int n = 1; n <= 40 && !done; n++) begin
            @(negedge CLK);
            if (n == 1)    bus.write_ready = 1'b0;
            if (n == hold) bus.read_ready  = 1'b0;
            rdy = wr ? bus.ready_send : bus.ready_read;
            if ((wr ? bus.ready_read : bus.ready_send) !== 1'b1) other_ok = 0;
            if (rdy === 1'b1) begin
                done = 1;
            end else begin
                low++;
                if (n <= 17 && bus.CS !== exp_cs) cs_ok = 0;
                if (!wr && bus.MOSI !== 1'b0) mosi_zero = 0;
            end
        end
        bus.read_ready = 1'b0;
        active = 1'b0;

        check({name, "/done"}, 32'(done), 32'd1);
        check({name, "/ready_low"}, 32'(low), 32'd18);
        check({name, "/cs_active"}, 32'(cs_ok), 32'd1);
        check({name, "/other_ready"}, 32'(other_ok), 32'd1);
        if (!wr) check({name, "/mosi_zero"}, 32'(mosi_zero), 32'd1);

        item = sb_q.pop_front();
        act  = item.is_write ? cap : bus.recieved_data;
        check({name, "/data"}, 32'(act), 32'(item.value));
        if (item.is_write) check({name, "/rx_hold"}, 32'(bus.recieved_data), 32'(last_read));
        else               last_read = item.value;

        check({name, "/sclk_idle"}, 32'(bus.SCLK), 32'(mode[1]));
        check({name, "/cs_idle"}, 32'(bus.CS), 32'({3{~inv}}));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;

        Reset               = 1'b0;
        bus.Mode            = 2'b00;
        bus.data_to_send    = 8'h00;
        bus.write_ready     = 1'b0;
        bus.read_ready      = 1'b0;
        bus.secondary_num_i = 2'd0;
        bus.flag_inv_i      = 1'b0;

        repeat (2) @(negedge CLK);
        check("rst/sclk", 32'(bus.SCLK), 32'd0);
        check("rst/mosi", 32'(bus.MOSI), 32'd0);
        check("rst/cs", 32'(bus.CS), 32'h7);
        check("rst/ready_send", 32'(bus.ready_send), 32'd1);
        check("rst/ready_read", 32'(bus.ready_read), 32'd1);
        check("rst/rx", 32'(bus.recieved_data), 32'd0);
        Reset = 1'b1;

        transfer("m10_w80", 1, 0, 2'b10, 2'd0, 0, 8'h80, 1);
        transfer("m10_wE6", 1, 0, 2'b10, 2'd0, 0, 8'hE6, 1);

        transfer("m11_r0A", 0, 0, 2'b11, 2'd0, 0, 8'h0A, 2);
        transfer("m11_r20", 0, 0, 2'b11, 2'd0, 0, 8'h20, 2);

        transfer("m00i_w08", 1, 0, 2'b00, 2'd1, 1, 8'h08, 1);
        transfer("m00i_w02", 1, 0, 2'b00, 2'd1, 1, 8'h02, 1);
        transfer("m00i_w03", 1, 0, 2'b00, 2'd1, 1, 8'h03, 1);

        transfer("m00_rC8", 0, 0, 2'b00, 2'd0, 0, 8'hC8, 1);
        transfer("m00_w5B", 1, 0, 2'b00, 2'd0, 0, 8'h5B, 1);

        // Reset in the middle of a write
        @(negedge CLK);
        bus.Mode            = 2'b10;
        bus.secondary_num_i = 2'd2;
        bus.flag_inv_i      = 1'b0;
        bus.data_to_send    = 8'hA5;
        bus.write_ready     = 1'b1;
        @(negedge CLK);
        bus.write_ready = 1'b0;
        repeat (8) @(negedge CLK);
        check("midrst/busy", 32'(bus.ready_send), 32'd0);
        #2 Reset = 1'b0;
        #1;
        check("midrst/cs", 32'(bus.CS), 32'h7);
        check("midrst/sclk", 32'(bus.SCLK), 32'd0);
        check("midrst/ready_send", 32'(bus.ready_send), 32'd1);
        check("midrst/mosi", 32'(bus.MOSI), 32'd0);
        check("midrst/rx", 32'(bus.recieved_data), 32'd0);
        last_read = 8'h00;
        @(negedge CLK);
        Reset = 1'b1;

        transfer("post_w01", 1, 0, 2'b00, 2'd0, 0, 8'h01, 1);

        // Out-of-range slave index must be ignored
        @(negedge CLK);
        bus.Mode            = 2'b11;
        bus.secondary_num_i = 2'd3;
        bus.flag_inv_i      = 1'b1;
        bus.data_to_send    = 8'hFF;
        bus.write_ready     = 1'b1;
        @(negedge CLK);
        bus.write_ready = 1'b0;
        ok = 1;
        repeat (20) begin
            @(negedge CLK);
            if (bus.ready_send !== 1'b1 || bus.ready_read !== 1'b1 ||
                bus.CS !== 3'b111 || bus.SCLK !== 1'b0) ok = 0;
        end
        check("slave3/idle", 32'(ok), 32'd1);

        transfer("wr_rd_both", 1, 1, 2'b01, 2'd2, 0, 8'h3C, 1);

        repeat (3) @(negedge CLK);
        check("final/ready_read", 32'(bus.ready_read), 32'd1);
        check("final/sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
